// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: edge-detects irq, drains the front end, pushes the return context, fetches the ISR vector and redirects fetch.
// Build option INT_SAVE_FLAGS_EN adds a third push carrying the flags word.
module int_sequencer #(
   parameter int            W            = 16,
   parameter int            PC_W         = 32,
   parameter int            DRAIN_CYCLES = 4,
   parameter logic [W-1:0]  VEC_ADDR     = 16'h0002
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             irq,
   input  logic             hold,
   input  logic [PC_W-1:0]  pc_next,
   input  logic [2:0]       flags,
   input  logic [W-1:0]     sp,
   input  logic             rti,
   input  logic             mem_ready,
   input  logic [W-1:0]     mem_rdata,
   output logic             stall_fetch,
   output logic             inject_nop,
   output logic             mem_req,
   output logic             mem_we,
   output logic [W-1:0]     mem_addr,
   output logic [W-1:0]     mem_wdata,
   output logic             sp_dec,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_target,
   output logic             in_isr
);

   localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, PENDING, DRAIN, PUSH_H, PUSH_L, PUSH_F, VEC_H, VEC_L, LOAD, ISR
   } state_t;

   state_t            state;
   logic              irq_q;
   logic              armed;
   logic              pend;
   logic [CNT_W-1:0]  cnt;
   logic [PC_W-1:0]   pc_cap;
   logic [W-1:0]      sp_cap;
   logic              irq_edge;

`ifdef INT_SAVE_FLAGS_EN
   logic [2:0]        flags_cap;
`else
   logic              unused_flags;
   assign unused_flags = ^flags;
`endif

   // armed blocks a level that was already high across reset from looking like a fresh edge
   assign irq_edge = irq & ~irq_q & armed;
   assign sp_dec   = mem_req & mem_we & mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         irq_q       <= 1'b0;
         armed       <= 1'b0;
         pend        <= 1'b0;
         cnt         <= '0;
         pc_cap      <= '0;
         sp_cap      <= '0;
`ifdef INT_SAVE_FLAGS_EN
         flags_cap   <= '0;
`endif
         stall_fetch <= 1'b0;
         inject_nop  <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         pc_load     <= 1'b0;
         pc_target   <= '0;
         in_isr      <= 1'b0;
      end else begin
         irq_q <= irq;
         armed <= 1'b1;

         if (irq_edge && state != IDLE && state != PENDING)
            pend <= 1'b1;

         case (state)
            IDLE: begin
               if (irq_edge || pend)
                  state <= PENDING;
            end

            PENDING: begin
               if (!hold) begin
                  state       <= DRAIN;
                  pc_cap      <= pc_next;
                  sp_cap      <= sp;
`ifdef INT_SAVE_FLAGS_EN
                  flags_cap   <= flags;
`endif
                  pend        <= 1'b0;
                  cnt         <= '0;
                  stall_fetch <= 1'b1;
                  inject_nop  <= 1'b1;
               end
            end

            DRAIN: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state      <= PUSH_H;
                  inject_nop <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_addr   <= sp_cap;
                  mem_wdata  <= pc_cap[PC_W-1:W];
               end
            end

            PUSH_H: begin
               if (mem_ready) begin
                  state     <= PUSH_L;
                  mem_addr  <= sp_cap - W'(1);
                  mem_wdata <= pc_cap[W-1:0];
               end
            end

            PUSH_L: begin
               if (mem_ready) begin
`ifdef INT_SAVE_FLAGS_EN
                  state     <= PUSH_F;
                  mem_addr  <= sp_cap - W'(2);
                  mem_wdata <= {{(W-3){1'b0}}, flags_cap};
`else
                  state     <= VEC_H;
                  mem_we    <= 1'b0;
                  mem_addr  <= VEC_ADDR;
                  mem_wdata <= '0;
`endif
               end
            end

            PUSH_F: begin
               if (mem_ready) begin
                  state     <= VEC_H;
                  mem_we    <= 1'b0;
                  mem_addr  <= VEC_ADDR;
                  mem_wdata <= '0;
               end
            end

            VEC_H: begin
               if (mem_ready) begin
                  state                <= VEC_L;
                  pc_target[PC_W-1:W]  <= mem_rdata;
                  mem_addr             <= VEC_ADDR + W'(1);
               end
            end

            VEC_L: begin
               if (mem_ready) begin
                  state            <= LOAD;
                  pc_target[W-1:0] <= mem_rdata;
                  mem_req          <= 1'b0;
                  mem_addr         <= '0;
                  stall_fetch      <= 1'b0;
                  pc_load          <= 1'b1;
               end
            end

            LOAD: begin
               state   <= ISR;
               pc_load <= 1'b0;
               in_isr  <= 1'b1;
            end

            ISR: begin
               if (rti) begin
                  state  <= IDLE;
                  in_isr <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   a_req_stable: assert property (@(posedge clk) disable iff (!rst)
      (mem_req && !mem_ready) |=> ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_we) && mem_req));

   a_load_pulse: assert property (@(posedge clk) disable iff (!rst)
      pc_load |=> !pc_load);

   a_nop_in_stall: assert property (@(posedge clk) disable iff (!rst)
      inject_nop |-> stall_fetch);

endmodule
